// File: rtl/hsv_stream_ctrl.sv
// hsv_stream_ctrl: stream wrapper around a fixed-latency RGB->HSV converter with tag pipeline, output FIFO and framing checks
// Ports: clk; rst (async, active-low); in_valid/in_sop/in_eop/in_r/in_g/in_b with in_ready (upstream);
// conv_r/g/b to the converter and conv_h/s/v back from it; out_valid/out_sop/out_eop/out_h/out_s/out_v
// with out_ready (downstream); err_proto sticky framing error; frame_cnt/pix_cnt statistics.
// Define HSV_STREAM_STATS_EN to build the counters; otherwise they read as 0.
module hsv_stream_ctrl #(
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic [7:0]  conv_r,
  output logic [7:0]  conv_g,
  output logic [7:0]  conv_b,
  input  logic [8:0]  conv_h,
  input  logic [7:0]  conv_s,
  input  logic [7:0]  conv_v,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  input  logic        out_ready,
  output logic [8:0]  out_h,
  output logic [7:0]  out_s,
  output logic [7:0]  out_v,
  output logic        err_proto,
  output logic [15:0] frame_cnt,
  output logic [19:0] pix_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(LATENCY + FIFO_DEPTH + 1);
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FRAME = 1'b1;
  logic [LATENCY-1:0] tag_v, tag_s, tag_e;
  logic [26:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic [OW-1:0]      occ;
  logic               state, state_nxt, acc, push, pop, bad;
  assign conv_r = in_r;
  assign conv_g = in_g;
  assign conv_b = in_b;
  assign acc = in_valid & in_ready;
  assign push = tag_v[LATENCY-1];
  assign out_valid = count != '0;
  assign pop = out_valid & out_ready;
  assign {out_h, out_s, out_v, out_sop, out_eop} = mem[rd_ptr];
  // Every accepted beat is either in flight or buffered, so capping their sum keeps the FIFO from overflowing.
  always_comb begin
    occ = OW'(count);
    for (int i = 0; i < LATENCY; i++) occ = occ + OW'(tag_v[i]);
  end
  assign in_ready = occ < OW'(FIFO_DEPTH);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v <= '0;
      tag_s <= '0;
      tag_e <= '0;
    end else begin
      tag_v[0] <= acc;
      tag_s[0] <= in_sop;
      tag_e[0] <= in_eop;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_s[i] <= tag_s[i-1];
        tag_e[i] <= tag_e[i-1];
      end
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {conv_h, conv_s, conv_v, tag_s[LATENCY-1], tag_e[LATENCY-1]};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // eop wins over sop, so a single-beat frame leaves the FSM idle.
  assign state_nxt = !acc ? state : in_eop ? ST_IDLE : in_sop ? ST_FRAME : state;
  assign bad = acc & (state == ST_IDLE ? ~in_sop : in_sop);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      err_proto <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_proto <= err_proto | bad;
    end
  end
`ifdef HSV_STREAM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      pix_cnt   <= '0;
    end else if (pop) begin
      pix_cnt   <= out_sop ? 20'd1 : pix_cnt == '1 ? pix_cnt : pix_cnt + 20'd1;
      frame_cnt <= frame_cnt + 16'(out_eop);
    end
  end
`else
  assign frame_cnt = '0;
  assign pix_cnt   = '0;
`endif
endmodule

// File: tb/tb_hsv_stream_ctrl.sv
// tb_hsv_stream_ctrl: table vectors, directed corner sequences and random traffic against a queue-based reference
module tb_hsv_stream_ctrl;
  localparam int L = 3;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, out_ready = 1'b0;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic in_ready, out_valid, out_sop, out_eop, err_proto;
  logic [7:0] conv_r, conv_g, conv_b, conv_s, conv_v, out_s, out_v;
  logic [8:0] conv_h, out_h;
  logic [15:0] frame_cnt;
  logic [19:0] pix_cnt;
  hsv_stream_ctrl #(.LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .conv_r(conv_r), .conv_g(conv_g), .conv_b(conv_b),
    .conv_h(conv_h), .conv_s(conv_s), .conv_v(conv_v), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .out_ready(out_ready), .out_h(out_h), .out_s(out_s), .out_v(out_v),
    .err_proto(err_proto), .frame_cnt(frame_cnt), .pix_cnt(pix_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [24:0] hsv(input int r, input int g, input int b);
    int mx, mn, d, h, s;
    mx = r > g ? (r > b ? r : b) : (g > b ? g : b);
    mn = r < g ? (r < b ? r : b) : (g < b ? g : b);
    d = mx - mn;
    if (d == 0) h = 0;
    else if (mx == r) h = (60 * (g - b) / d + 360) % 360;
    else if (mx == g) h = 120 + 60 * (b - r) / d;
    else h = 240 + 60 * (r - g) / d;
    s = mx == 0 ? 0 : 255 * d / mx;
    return {9'(h), 8'(s), 8'(mx)};
  endfunction
  logic [24:0] cp [L];
  always @(posedge clk) begin
    cp[0] <= hsv(conv_r, conv_g, conv_b);
    for (int i = 1; i < L; i++) cp[i] <= cp[i-1];
  end
  assign {conv_h, conv_s, conv_v} = cp[L-1];
  typedef struct { int rdy; logic [26:0] d; } ent_t;
  ent_t q[$];
  int n_chk = 0, n_err = 0, cyc = 0, pix_m = 0;
  int dut_acc = 0, dut_pop = 0, dut_ov = 0;
  logic [15:0] frm_m = '0;
  logic err_m = 1'b0, in_frame = 1'b0, exp_ready, exp_ov;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic ordy);
    in_valid = v; in_sop = s; in_eop = e; in_r = r; in_g = g; in_b = b; out_ready = ordy;
  endtask
  task automatic sample();
    @(negedge clk);
    exp_ready = q.size() < D;
    exp_ov = q.size() > 0 && q[0].rdy <= cyc;
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_ov);
    check("err_proto", err_proto, err_m);
    check("conv_rgb", {conv_r, conv_g, conv_b}, {in_r, in_g, in_b});
    if (exp_ov && out_ready) check("out_data", {out_h, out_s, out_v, out_sop, out_eop}, q[0].d);
`ifdef HSV_STREAM_STATS_EN
    check("pix_cnt", pix_cnt, pix_m);
    check("frame_cnt", frame_cnt, frm_m);
`else
    check("pix_cnt", pix_cnt, 0);
    check("frame_cnt", frame_cnt, 0);
`endif
    if (in_valid && in_ready) dut_acc++;
    if (out_valid && out_ready) dut_pop++;
    if (out_valid) dut_ov++;
  endtask
  task automatic advance();
    if (in_valid && exp_ready) begin
      q.push_back('{cyc + L + 1, {hsv(in_r, in_g, in_b), in_sop, in_eop}});
      if ((!in_frame && !in_sop) || (in_frame && in_sop)) err_m = 1'b1;
      in_frame = in_eop ? 1'b0 : in_sop ? 1'b1 : in_frame;
    end
    if (exp_ov && out_ready) begin
      if (q[0].d[1]) pix_m = 1;
      else if (pix_m != 20'hFFFFF) pix_m++;
      if (q[0].d[0]) frm_m++;
      void'(q.pop_front());
    end
    @(posedge clk);
    #1 cyc++;
  endtask
  task automatic step();
    sample();
    advance();
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk);
    q.delete();
    err_m = 0; in_frame = 0; pix_m = 0; frm_m = '0;
    #1 rst = 1'b1;
    cyc++;
  endtask
  typedef struct { logic iv, sop, eop; logic [7:0] r, g, b; logic ordy; logic ov, ir; logic [26:0] od; } vec_t;
  vec_t tbl [13];
  initial begin
    tbl[0]  = '{1, 1, 1, 255, 0, 0, 1, 0, 1, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, {9'd0, 8'd255, 8'd255, 2'b11}};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    tbl[6]  = '{1, 1, 0, 0, 255, 0, 1, 0, 1, 0};
    tbl[7]  = '{1, 0, 1, 0, 0, 255, 1, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, {9'd120, 8'd255, 8'd255, 2'b10}};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, {9'd240, 8'd255, 8'd255, 2'b01}};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].sop, tbl[i].eop, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].ordy);
      sample();
      check("tbl_out_valid", out_valid, tbl[i].ov);
      check("tbl_in_ready", in_ready, tbl[i].ir);
      if (tbl[i].ov) check("tbl_out_data", {out_h, out_s, out_v, out_sop, out_eop}, tbl[i].od);
      advance();
    end
    dut_acc = 0;
    begin
      int n = 0;
      for (int k = 0; k < 10; k++) begin
        if (n < 4) drive(1, n == 0, n == 3, 8'(40 * n + 10), 8'(200 - 30 * n), 8'(7 * n), 0);
        else drive(1, 1, 1, 8'd90, 8'd90, 8'd200, 0);
        sample();
        if (in_valid && exp_ready) n++;
        advance();
      end
    end
    check("bp_accepted", dut_acc, 4);
    check("bp_in_ready_low", in_ready, 0);
    dut_pop = 0;
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (8) step();
    check("bp_drained", dut_pop, 4);
    dut_pop = 0;
    drive(1, 0, 0, 8'd10, 8'd20, 8'd30, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    sample();
    check("err_set", err_proto, 1);
    advance();
    repeat (6) step();
    check("err_pixel_out", dut_pop, 1);
    check("err_sticky", err_proto, 1);
    drive(1, 1, 0, 8'd1, 8'd2, 8'd3, 1);
    step();
    drive(1, 0, 0, 8'd4, 8'd5, 8'd6, 1);
    step();
    drive(1, 0, 1, 8'd7, 8'd8, 8'd9, 1);
    step();
    do_reset();
    check("rst_err_clear", err_proto, 0);
    dut_ov = 0;
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (8) step();
    check("rst_no_stale", dut_ov, 0);
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 5; p++) begin
        drive(1, p == 0, p == 4, 8'(30 * p + f), 8'(100 + p), 8'(250 - 20 * p), 1);
        step();
      end
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (8) step();
`ifdef HSV_STREAM_STATS_EN
    check("stats_frames", frame_cnt, 2);
    check("stats_pixels", pix_cnt, 5);
`else
    check("stats_frames", frame_cnt, 0);
    check("stats_pixels", pix_cnt, 0);
`endif
    do_reset();
    repeat (400) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 9) < 6);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (10) step();
    check("rand_drained", out_valid, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
